// File: rtl/reg_readout_shifter_pkg.sv
// Shared definitions for the register readout shifter: state encoding and the
// default word/address sizes used by the register bank it reads from.
package reg_readout_shifter_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    PAR   = 3'd4
  } state_e;

endpackage

// File: rtl/reg_readout_shifter_piso_shift_reg.sv
// Parallel-in serial-out shift register built from one enable/clear flop per
// bit. Shifts right with zero fill; a load takes priority over a shift.
module piso_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             lsb_o
);

  logic [WIDTH:0] chain;
  logic           bitEn;

  assign chain[WIDTH] = 1'b0;
  assign bitEn        = load_i | shift_i;
  assign lsb_o        = chain[0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bit_q;
    logic bit_d;

    assign bit_d    = load_i ? data_i[i] : chain[i+1];
    assign chain[i] = bit_q;

    // Per-bit enable/clear flop: loads the parallel word or takes its left neighbour.
    always_ff @(posedge clk_i or posedge clr_i) begin
      if (clr_i) begin
        bit_q <= 1'b0;
      end else if (bitEn) begin
        bit_q <= bit_d;
      end
    end
  end

endmodule

// File: rtl/reg_readout_shifter.sv
// Register readout shifter: on start, fetches one word from a register bank and
// serializes it LSB-first. en stalls all progress. Optional trailing even-parity
// bit is compiled in with the READOUT_PARITY_EN macro.
module reg_readout_shifter
  import reg_readout_shifter_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              sout,
  output logic              sout_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
  logic              loadWord;
  logic              shiftWord;
  logic              shiftLsb;

  // Serializer storage; the word is captured when FETCH is left.
  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk_i  (clk),
    .clr_i  (clr),
    .load_i (loadWord),
    .shift_i(shiftWord),
    .data_i (rd_data),
    .lsb_o  (shiftLsb)
  );

`ifdef READOUT_PARITY_EN
  logic parity_q;

  // Even parity of the captured word, taken at the same moment as the word itself.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      parity_q <= 1'b0;
    end else if (loadWord) begin
      parity_q <= ^rd_data;
    end
  end
`endif

  // State, bit counter and bank address registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdAddr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdAddr_q <= rdAddr_d;
    end
  end

  // Next-state logic; nothing moves while en is low except the DONE->IDLE step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdAddr_d  = rdAddr_q;
    loadWord  = 1'b0;
    shiftWord = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && en) begin
          rdAddr_d = addr;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (en) begin
          loadWord = 1'b1;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          shiftWord = 1'b1;
          if (cnt_q == CNT_LAST) begin
`ifdef READOUT_PARITY_EN
            state_d = PAR;
`else
            state_d = DONE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef READOUT_PARITY_EN
      PAR: begin
        if (en) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only, so they freeze during a stall.
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    case (state_q)
      SHIFT: begin
        sout       = shiftLsb;
        sout_valid = 1'b1;
      end
`ifdef READOUT_PARITY_EN
      PAR: begin
        sout       = parity_q;
        sout_valid = 1'b1;
      end
`endif
      default: begin
        sout       = 1'b0;
        sout_valid = 1'b0;
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign rd_addr = rdAddr_q;

endmodule

// File: tb/tb_reg_readout_shifter.sv
// Testbench for reg_readout_shifter: table-driven readouts plus hand-written
// reset, back-to-back and reset-abort sequences, with a bit scoreboard.
module tb_reg_readout_shifter;

  localparam int W  = 32;
  localparam int AW = 5;
`ifdef READOUT_PARITY_EN
  localparam int PAR_EXTRA = 1;
`else
  localparam int PAR_EXTRA = 0;
`endif
  localparam int DONE_K = 2 + W + PAR_EXTRA;

  logic          clk = 1'b0;
  logic          clr;
  logic          en;
  logic          start;
  logic [AW-1:0] addr;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          sout;
  logic          sout_valid;
  logic          busy;
  logic          done;

  logic [W-1:0] bank [2**AW];
  assign rd_data = bank[rd_addr];

  always #5 clk = ~clk;

  reg_readout_shifter #(
    .WIDTH (W),
    .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .start     (start),
    .addr      (addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .sout      (sout),
    .sout_valid(sout_valid),
    .busy      (busy),
    .done      (done)
  );

  int totalCnt = 0;
  int badCnt   = 0;
  bit expQ[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  word;
    int            stallAt;
    int            stallLen;
    int            strayAt;
    int            changeAt;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    totalCnt++;
    if (act !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushWord(input logic [W-1:0] word);
    for (int i = 0; i < W; i++) expQ.push_back(word[i]);
    if (PAR_EXTRA == 1) expQ.push_back(^word);
  endtask

  // Scoreboard: every consumed serial bit must match the next expected one.
  always @(negedge clk) begin
    if (!clr && sout_valid && en) begin
      if (expQ.size() == 0) begin
        totalCnt++;
        badCnt++;
        $display("[TB] FAIL unexpected_bit actual=%0b required=none at %0t", sout, $time);
      end else begin
        bit e;
        e = expQ.pop_front();
        checkOutput("sout_bit", {31'd0, sout}, {31'd0, e});
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    int doneK;
    bank[v.addr] = v.word;
    @(posedge clk); #1;
    start = 1'b1;
    addr  = v.addr;
    en    = 1'b1;
    pushWord(v.word);
    @(posedge clk); #1;
    start = 1'b0;
    doneK = DONE_K + v.stallLen;
    for (int k = 1; k <= doneK + 2; k++) begin
      en    = !(v.stallLen > 0 && k >= 2 + v.stallAt && k < 2 + v.stallAt + v.stallLen);
      start = (k == v.strayAt);
      if (k == v.strayAt) addr = 5'd7;
      if (k == v.changeAt) bank[v.addr] = ~v.word;
      @(negedge clk);
      checkOutput("done", {31'd0, done}, {31'd0, (k == doneK)});
      checkOutput("busy", {31'd0, busy}, {31'd0, (k <= doneK)});
      if (!en) checkOutput("stall_sout", {30'd0, sout_valid, sout}, {30'd0, 1'b1, v.word[v.stallAt]});
      @(posedge clk); #1;
    end
    start = 1'b0;
    en    = 1'b1;
    checkOutput("rd_addr", {27'd0, rd_addr}, {27'd0, v.addr});
    checkOutput("queue_empty", expQ.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{5'd5,  32'hA5A5_0F0F, 0,  0, 0,  0};
    vecs[1] = '{5'd5,  32'hA5A5_0F0F, 10, 3, 0,  0};
    vecs[2] = '{5'd5,  32'hA5A5_0F0F, 0,  0, 12, 0};
    vecs[3] = '{5'd9,  32'h0000_0007, 0,  0, 0,  0};
    vecs[4] = '{5'd31, 32'hFFFF_FFFF, 0,  0, 0,  3};
    vecs[5] = '{5'd0,  32'h8000_0001, 0,  2, 0,  0};
    vecs[6] = '{5'd17, 32'h1234_5678, 31, 1, 0,  0};

    for (int i = 0; i < 2**AW; i++) bank[i] = 32'h0;
    bank[7] = 32'hDEAD_BEEF;

    clr   = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {28'd0, sout, sout_valid, busy, done}, 32'd0);
    checkOutput("reset_rd_addr", {27'd0, rd_addr}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    checkOutput("idle_outputs", {28'd0, sout, sout_valid, busy, done}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      bank[7] = 32'hDEAD_BEEF;
    end

    // Reset mid-transaction at bit 20: asynchronous abort, no done pulse.
    bank[3] = 32'h0F1E_2D3C;
    @(posedge clk); #1;
    start = 1'b1;
    addr  = 5'd3;
    en    = 1'b1;
    pushWord(32'h0F1E_2D3C);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    checkOutput("abort_outputs", {28'd0, sout, sout_valid, busy, done}, 32'd0);
    checkOutput("abort_rd_addr", {27'd0, rd_addr}, 32'd0);
    expQ.delete();
    @(posedge clk); #1;
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("post_abort_ctl", {30'd0, busy, done}, 32'd0);
    end
    applyStimulus(vecs[0]);

    // Back-to-back: start held high, second word accepted after DONE plus one IDLE.
    bank[1] = 32'h3C3C_A5A5;
    bank[2] = 32'h0123_4567;
    @(posedge clk); #1;
    start = 1'b1;
    addr  = 5'd1;
    en    = 1'b1;
    pushWord(32'h3C3C_A5A5);
    pushWord(32'h0123_4567);
    @(posedge clk); #1;
    addr = 5'd2;
    for (int k = 1; k <= 2 * DONE_K + 2; k++) begin
      if (k == 2 * DONE_K + 1) start = 1'b0;
      @(negedge clk);
      checkOutput("b2b_done", {31'd0, done}, {31'd0, (k == DONE_K || k == 2 * DONE_K + 1)});
      checkOutput("b2b_busy", {31'd0, busy}, {31'd0, (k != DONE_K + 1 && k <= 2 * DONE_K + 1)});
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("b2b_rd_addr", {27'd0, rd_addr}, 32'd2);
    checkOutput("b2b_queue_empty", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule

// File: doc/reg_readout_shifter.md
Name: reg_readout_shifter

Overview:
- Reader-side counterpart to the team's enable/clear flip-flop storage: fetches one word from a register bank built of those flops and serializes it LSB-first.
- Used for debug and readout of game state, e.g. to a UART or an LED/segment display driver.
- A start pulse with an address launches a fetch-then-shift transaction.
- A stall input (en) freezes progress, mirroring flop enable semantics.

Parameters:
- WIDTH, 32, data word width in bits; must be >= 2.
- ADDR_W, 5, register bank address width.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- clr  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; when low, all internal state holds (except clr).
- start  input  1  request a readout; sampled only in IDLE with en=1.
- addr  input  ADDR_W  register index; captured with start.
- rd_addr  output  ADDR_W  address driven to the register bank read port.
- rd_data  input  WIDTH  combinational read data from the bank, valid the cycle after rd_addr is stable.
- sout  output  1  serial data bit.
- sout_valid  output  1  high while sout carries a payload bit.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset (clr high, asynchronous):
  - state=IDLE; rd_addr, shift register, and bit counter all 0.
  - sout=0, sout_valid=0, busy=0, done=0.
  - Reset mid-transaction aborts immediately; no done pulse is issued.
- States:
  - IDLE -> FETCH on start&en. addr is latched into rd_addr.
  - FETCH: one cycle for the bank to settle. Leaves on en: rd_data is captured into the shift register, counter=0 -> SHIFT.
  - SHIFT:
    - sout = shift_reg[0], sout_valid=1.
    - Each en cycle: shift right by one (zero fill), counter++.
    - When counter==WIDTH-1 and en -> DONE (or PAR when the parity feature is compiled in).
  - DONE: done=1 for exactly one cycle, sout_valid=0; -> IDLE unconditionally. done ignores en.
- en low in FETCH or SHIFT:
  - State, counter, and shift register hold.
  - sout and sout_valid keep their current values.
  - The consumer counts a bit only on cycles with sout_valid&en.
- Latency:
  - start accepted at cycle T.
  - First valid bit at T+2.
  - Last bit at T+1+WIDTH.
  - done at T+2+WIDTH (with en held high throughout).
- start while busy: ignored, not queued.
- start in the same cycle as DONE: ignored. The earliest new accept is in the following IDLE cycle.
- rd_addr: holds its value from FETCH until the next accepted start.
- Word capture: rd_data changing after FETCH capture does not affect the serialized word.
- Width rules:
  - Counter is ceil(log2(WIDTH)) bits.
  - No wrap: the counter compare ends SHIFT before overflow.

Optional Feature:
- Macro: READOUT_PARITY_EN.
- Defined:
  - After the last data bit, state PAR drives sout = XOR of all WIDTH captured bits (even parity) with sout_valid=1, for one en-qualified cycle.
  - Then DONE. done therefore occurs at T+3+WIDTH.
- Undefined:
  - PAR state and parity logic are absent; SHIFT goes directly to DONE.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=0, FETCH=1, SHIFT=2, DONE=3, PAR=4; 3-bit state.
  - Default WIDTH and ADDR_W constants shared with the register bank.
- One sub-module: piso_shift_reg.
  - WIDTH-bit parallel-load, shift-right register with en and async clr.
  - Built from per-bit enable/clear flops.
  - Load has priority over shift.

Test Plan:
- Basic readout:
  - Stimulus: clr pulse, then start with addr=5; bank word 0xA5A5_0F0F; en held high.
  - Required: bits 1,1,1,1,0,0,0,0,... LSB-first on cycles T+2..T+33; done at T+34; busy low at T+35.
- Stall:
  - Stimulus: same as basic readout, but drop en for 3 cycles at bit 10.
  - Required: sout frozen at bit 10 during the stall; done delayed to T+37; captured word still 0xA5A5_0F0F.
- Start while busy:
  - Stimulus: second start with addr=7 mid-SHIFT.
  - Required: ignored; rd_addr stays 5; only one done pulse.
- Reset mid-operation:
  - Stimulus: assert clr asynchronously at bit 20.
  - Required: same-cycle (no clock edge) all outputs 0, state IDLE; no done pulse; a new start works normally afterwards.
- Back-to-back:
  - Stimulus: start asserted continuously.
  - Required: words separated by a DONE cycle plus one IDLE cycle; each word serialized intact.
- Parity (READOUT_PARITY_EN defined):
  - Stimulus: word 0x0000_0007.
  - Required: 32 data bits, then parity bit 1; done at T+35.
